// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared op codes, ALUOp/Funct7 encodings and M-sequencer states
//               for the EX-stage ALU control.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam int c_OP_W = 5;
    typedef logic [c_OP_W-1:0] op_t;

    localparam op_t c_OP_AND     = 5'b00000;
    localparam op_t c_OP_OR      = 5'b00001;
    localparam op_t c_OP_ADD     = 5'b00010;
    localparam op_t c_OP_XOR     = 5'b00011;
    localparam op_t c_OP_SLL     = 5'b00100;
    localparam op_t c_OP_SRL     = 5'b00101;
    localparam op_t c_OP_SUB     = 5'b00110;
    localparam op_t c_OP_SLT     = 5'b00111;
    localparam op_t c_OP_SLTU    = 5'b01000;
    localparam op_t c_OP_SRA     = 5'b01001;
    localparam op_t c_OP_INVALID = 5'b01111;
    // M ops are 1_0_{Funct3}; only the base of that range is named
    localparam op_t c_OP_MUL     = 5'b10000;

    localparam logic [1:0] c_ALUOP_LDST   = 2'b00;
    localparam logic [1:0] c_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] c_ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational ALUOp/Funct7/Funct3 to operation code decode.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [1:0]        ALUOp,
    input  logic [6:0]        Funct7,
    input  logic [2:0]        Funct3,
    output logic [c_OP_W-1:0] Operation
);

    always_comb begin
        Operation = c_OP_INVALID;
        unique case (ALUOp)
            c_ALUOP_LDST:   Operation = c_OP_ADD;
            c_ALUOP_BRANCH: Operation = c_OP_SUB;
            c_ALUOP_RTYPE: begin
                if (ENABLE_M && (Funct7 == c_F7_MULDIV)) begin
                    Operation = {c_OP_MUL[4:3], Funct3};
                end else begin
                    case ({Funct7, Funct3})
                        {c_F7_BASE, 3'b000}: Operation = c_OP_ADD;
                        {c_F7_ALT,  3'b000}: Operation = c_OP_SUB;
                        {c_F7_BASE, 3'b001}: Operation = c_OP_SLL;
                        {c_F7_BASE, 3'b010}: Operation = c_OP_SLT;
                        {c_F7_BASE, 3'b011}: Operation = c_OP_SLTU;
                        {c_F7_BASE, 3'b100}: Operation = c_OP_XOR;
                        {c_F7_BASE, 3'b101}: Operation = c_OP_SRL;
                        {c_F7_ALT,  3'b101}: Operation = c_OP_SRA;
                        {c_F7_BASE, 3'b110}: Operation = c_OP_OR;
                        {c_F7_BASE, 3'b111}: Operation = c_OP_AND;
                        default:             Operation = c_OP_INVALID;
                    endcase
                end
            end
            c_ALUOP_ITYPE: begin
                // Funct7 only qualifies the shift-immediate forms
                case (Funct3)
                    3'b000: Operation = c_OP_ADD;
                    3'b001: Operation = (Funct7 == c_F7_BASE) ? c_OP_SLL : c_OP_INVALID;
                    3'b010: Operation = c_OP_SLT;
                    3'b011: Operation = c_OP_SLTU;
                    3'b100: Operation = c_OP_XOR;
                    3'b101: begin
                        if (Funct7 == c_F7_BASE)     Operation = c_OP_SRL;
                        else if (Funct7 == c_F7_ALT) Operation = c_OP_SRA;
                        else                         Operation = c_OP_INVALID;
                    end
                    3'b110: Operation = c_OP_OR;
                    default: Operation = c_OP_AND;
                endcase
            end
            default: Operation = c_OP_INVALID;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_md_controller.sv
`default_nettype none
// ============================================================================
// Module      : alu_md_controller
// Description : EX-stage ALU control with multi-cycle multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_md_controller
    import alu_ctrl_pkg::*;
#(
    parameter bit          ENABLE_M = 1'b1,
    parameter int unsigned MUL_LAT  = 4,
    parameter int unsigned DIV_LAT  = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [1:0]        ALUOp,
    input  logic [6:0]        Funct7,
    input  logic [2:0]        Funct3,
    output logic [c_OP_W-1:0] Operation,
    output logic              illegal,
    output logic              md_start,
    output logic              md_busy,
    output logic              md_done,
    output logic              stall
);

    md_state_t  r_state;
    md_state_t  w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_lat;
    logic       w_is_md;

    alu_op_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .ALUOp     (ALUOp),
        .Funct7    (Funct7),
        .Funct3    (Funct3),
        .Operation (Operation)
    );

    assign w_is_md = Operation[4];
    assign w_lat   = Funct3[2] ? 8'(DIV_LAT) : 8'(MUL_LAT);
    assign illegal = valid_i && (Operation == c_OP_INVALID);
    assign md_busy = (r_state == S_BUSY);
    assign md_done = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        md_start    = 1'b0;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_i && w_is_md && !flush_i) begin
                    md_start    = 1'b1;
                    stall       = 1'b1;
                    w_cnt_nxt   = w_lat - 8'd1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                // flush beats the final count so a killed op never reports done
                if (flush_i) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (flush_i) begin
                    w_cnt_nxt = 8'd0;
                end
            end
            default: begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_md_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_md_controller
// Description : Directed self-checking bench for alu_md_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_md_controller;

    logic       clk = 1'b0;
    logic       reset, valid_i, flush_i;
    logic [1:0] ALUOp;
    logic [6:0] Funct7;
    logic [2:0] Funct3;

    logic [4:0] op1, op0;
    logic       ill1, start1, busy1, done1, stall1;
    logic       ill0, start0, busy0, done0, stall0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_md_controller #(.ENABLE_M(1'b1), .MUL_LAT(4), .DIV_LAT(33)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .Operation(op1), .illegal(ill1), .md_start(start1), .md_busy(busy1),
        .md_done(done1), .stall(stall1)
    );

    alu_md_controller #(.ENABLE_M(1'b0), .MUL_LAT(4), .DIV_LAT(33)) dut_nom (
        .clk(clk), .reset(reset), .valid_i(valid_i), .flush_i(flush_i),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3),
        .Operation(op0), .illegal(ill0), .md_start(start0), .md_busy(busy0),
        .md_done(done0), .stall(stall0)
    );

    // {ALUOp, Funct7, Funct3, expected Operation}
    logic [16:0] vec [0:28] = '{
        {2'b10, 7'b0000000, 3'b000, 5'b00010},
        {2'b10, 7'b0100000, 3'b000, 5'b00110},
        {2'b10, 7'b0000000, 3'b111, 5'b00000},
        {2'b10, 7'b0000000, 3'b110, 5'b00001},
        {2'b10, 7'b0000000, 3'b100, 5'b00011},
        {2'b10, 7'b0000000, 3'b001, 5'b00100},
        {2'b10, 7'b0000000, 3'b101, 5'b00101},
        {2'b10, 7'b0100000, 3'b101, 5'b01001},
        {2'b10, 7'b0000000, 3'b010, 5'b00111},
        {2'b10, 7'b0000000, 3'b011, 5'b01000},
        {2'b10, 7'b0100000, 3'b111, 5'b01111},
        {2'b10, 7'b0000001, 3'b000, 5'b10000},
        {2'b10, 7'b0000001, 3'b011, 5'b10011},
        {2'b10, 7'b0000001, 3'b100, 5'b10100},
        {2'b10, 7'b0000001, 3'b111, 5'b10111},
        {2'b10, 7'b1111111, 3'b000, 5'b01111},
        {2'b11, 7'b0100000, 3'b000, 5'b00010},
        {2'b11, 7'b1111111, 3'b010, 5'b00111},
        {2'b11, 7'b0000001, 3'b011, 5'b01000},
        {2'b11, 7'b0100000, 3'b100, 5'b00011},
        {2'b11, 7'b1111111, 3'b110, 5'b00001},
        {2'b11, 7'b0000001, 3'b111, 5'b00000},
        {2'b11, 7'b0000000, 3'b001, 5'b00100},
        {2'b11, 7'b0100000, 3'b001, 5'b01111},
        {2'b11, 7'b0000000, 3'b101, 5'b00101},
        {2'b11, 7'b0100000, 3'b101, 5'b01001},
        {2'b11, 7'b1111111, 3'b101, 5'b01111},
        {2'b00, 7'b1111111, 3'b101, 5'b00010},
        {2'b01, 7'b0000001, 3'b100, 5'b00110}
    };

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Moves to 1 time unit after the next rising edge; cycle boundary for checks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [1:0] a, input logic [6:0] f7, input logic [2:0] f3);
        valid_i = v;
        ALUOp   = a;
        Funct7  = f7;
        Funct3  = f3;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  {7'd0, busy1},  8'd0);
        chk({tag, "_done"},  {7'd0, done1},  8'd0);
        chk({tag, "_stall"}, {7'd0, stall1}, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] exp_op;
        reset = 1'b1; flush_i = 1'b0;
        set_ins(1'b0, 2'b00, 7'd0, 3'd0);
        step(); step();
        #1;
        chk("rst_busy", {7'd0, busy1}, 8'd0);
        chk("rst_done", {7'd0, done1}, 8'd0);
        chk("rst_stall", {7'd0, stall1}, 8'd0);
        chk("rst_start", {7'd0, start1}, 8'd0);
        reset = 1'b0;
        step();

        // Decode sweep: flush held so M encodings cannot issue.
        flush_i = 1'b1;
        for (int i = 0; i < 29; i++) begin
            exp_op = vec[i][4:0];
            set_ins(1'b1, vec[i][16:15], vec[i][14:8], vec[i][7:5]);
            #1;
            chk($sformatf("dec%0d_op", i), {3'd0, op1}, {3'd0, exp_op});
            chk($sformatf("dec%0d_ill", i), {7'd0, ill1}, {7'd0, exp_op == 5'b01111});
            chk($sformatf("dec%0d_op_nom", i), {3'd0, op0},
                {3'd0, exp_op[4] ? 5'b01111 : exp_op});
            chk($sformatf("dec%0d_start", i), {7'd0, start1}, 8'd0);
        end
        for (int f = 0; f < 8; f++) begin
            set_ins(1'b1, 2'b00, 7'b0100000, 3'(f)); #1;
            chk($sformatf("ld%0d", f), {3'd0, op1}, 8'b00010);
            set_ins(1'b1, 2'b01, 7'b1111111, 3'(f)); #1;
            chk($sformatf("br%0d", f), {3'd0, op1}, 8'b00110);
            set_ins(1'b1, 2'b10, 7'b1111111, 3'(f)); #1;
            chk($sformatf("r7f%0d", f), {3'd0, op1}, 8'b01111);
        end
        flush_i = 1'b0;

        // valid_i low with an M encoding: decodes but never issues
        set_ins(1'b0, 2'b10, 7'b0000001, 3'b000); #1;
        chk("nv_op", {3'd0, op1}, 8'b10000);
        chk("nv_start", {7'd0, start1}, 8'd0);
        chk("nv_ill", {7'd0, ill1}, 8'd0);
        step();
        chk("nv_busy", {7'd0, busy1}, 8'd0);

        // MUL, latency 4
        set_ins(1'b1, 2'b10, 7'b0000001, 3'b000); #1;
        chk("mul_c0_start", {7'd0, start1}, 8'd1);
        chk("mul_c0_stall", {7'd0, stall1}, 8'd1);
        chk("nom_start", {7'd0, start0}, 8'd0);
        chk("nom_stall", {7'd0, stall0}, 8'd0);
        chk("nom_ill", {7'd0, ill0}, 8'd1);
        chk("nom_op", {3'd0, op0}, 8'b01111);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("mul_c%0d_busy", c), {7'd0, busy1}, {7'd0, c <= 4});
            chk($sformatf("mul_c%0d_stall", c), {7'd0, stall1}, {7'd0, c <= 4});
            chk($sformatf("mul_c%0d_done", c), {7'd0, done1}, {7'd0, c == 5});
            chk($sformatf("mul_c%0d_start", c), {7'd0, start1}, 8'd0);
        end
        chk("nom_busy", {7'd0, busy0}, 8'd0);
        valid_i = 1'b0;
        step();
        chk_idle("mul_c6");

        // Two back-to-back DIVs, latency 33
        set_ins(1'b1, 2'b10, 7'b0000001, 3'b100); #1;
        chk("div_c0_start", {7'd0, start1}, 8'd1);
        for (int c = 1; c <= 69; c++) begin
            step();
            if (c == 34) begin
                chk("div_c34_done", {7'd0, done1}, 8'd1);
                chk("div_c34_start", {7'd0, start1}, 8'd0);
                chk("div_c34_stall", {7'd0, stall1}, 8'd0);
            end else if (c == 35) begin
                chk("div_c35_start", {7'd0, start1}, 8'd1);
            end else if (c == 33 || c == 68) begin
                chk($sformatf("div_c%0d_busy", c), {7'd0, busy1}, 8'd1);
                chk($sformatf("div_c%0d_done", c), {7'd0, done1}, 8'd0);
            end
        end
        chk("div2_c69_done", {7'd0, done1}, 8'd1);
        valid_i = 1'b0;
        step();
        chk_idle("div2_after");

        // Flush in cycle 2 of a MUL
        set_ins(1'b1, 2'b10, 7'b0000001, 3'b001);
        step();
        step();
        chk("fl_c2_busy", {7'd0, busy1}, 8'd1);
        flush_i = 1'b1; valid_i = 1'b0;
        step();
        flush_i = 1'b0; #1;
        chk_idle("fl_c3");
        step();
        chk("fl_c4_done", {7'd0, done1}, 8'd0);

        // Flush on the final BUSY cycle (cnt==0)
        set_ins(1'b1, 2'b10, 7'b0000001, 3'b000);
        for (int c = 1; c <= 4; c++) step();
        chk("flz_c4_busy", {7'd0, busy1}, 8'd1);
        flush_i = 1'b1; valid_i = 1'b0;
        step();
        flush_i = 1'b0; #1;
        chk_idle("flz_c5");

        // Reset mid-DIV
        set_ins(1'b1, 2'b10, 7'b0000001, 3'b110);
        for (int c = 1; c <= 5; c++) step();
        chk("rd_busy", {7'd0, busy1}, 8'd1);
        reset = 1'b1; valid_i = 1'b0;
        step();
        reset = 1'b0; #1;
        chk_idle("rd_after");

        // Reset and flush together mid-DIV
        set_ins(1'b1, 2'b10, 7'b0000001, 3'b101);
        for (int c = 1; c <= 3; c++) step();
        reset = 1'b1; flush_i = 1'b1; valid_i = 1'b0;
        step();
        reset = 1'b0; flush_i = 1'b0; #1;
        chk_idle("rf_after");
        step();
        chk("rf_done", {7'd0, done1}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_md_controller.md
# alu_md_controller

Second-generation ALU control for the single-cycle/EX-stage RISC-V core: decodes ALUOp/Funct7/Funct3 into a widened operation code covering RV32I register, immediate and RV32M forms. It also sequences multi-cycle multiply/divide operations, issuing a start pulse to the M-unit and stalling the pipeline for a parametrised latency. It sits between the main control unit and the ALU / M-unit in EX.

## Interface
- `ENABLE_M`, 1: 1 decodes RV32M; 0 makes every Funct7=0000001 op illegal.
- `MUL_LAT`, 4: busy cycles for MUL/MULH/MULHSU/MULHU; legal range 1..255.
- `DIV_LAT`, 33: busy cycles for DIV/DIVU/REM/REMU; legal range 1..255.
- `OP_W`, 5: Operation width; fixed at 5 and not overridable.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_i` in 1: EX holds a valid instruction.
- `flush_i` in 1: synchronous abort of the in-flight M op.
- `ALUOp` in 2: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- `Funct7` in 7: instruction[31:25].
- `Funct3` in 3: instruction[14:12].
- `Operation` out 5: ALU/M-unit op code, combinational.
- `illegal` out 1: `valid_i` and the op decodes invalid.
- `md_start` out 1: one-cycle start pulse to the M-unit.
- `md_busy` out 1: FSM in BUSY.
- `md_done` out 1: one-cycle pulse, M result valid this cycle.
- `stall` out 1: hold PC/IF/ID/EX this cycle.

## Operation
- Base codes:
  - ADD 00010, SUB 00110, AND 00000, OR 00001, XOR 00011.
  - SLL 00100, SRL 00101, SRA 01001, SLT 00111, SLTU 01000.
  - INVALID 01111.
- ALUOp decode:
  - 00 → ADD.
  - 01 → SUB.
  - 10: exact {Funct7,Funct3} match for the base set as before.
  - 10 with Funct7=0000001 and ENABLE_M=1 → 1_0_{Funct3}: MUL 10000 … REMU 10111.
  - 11: Funct3 only, Funct7 ignored, except shifts. 000 ADD (never SUB), 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - 11 shifts: 001 needs Funct7=0000000 → SLL. 101 with 0000000 → SRL, with 0100000 → SRA.
  - Anything else → INVALID.
- `Operation` is pure decode of the inputs, independent of state and reset.
- `is_md` = Operation[4].
- `is_md` & Funct3[2]=0 selects MUL_LAT; Funct3[2]=1 selects DIV_LAT.
- FSM states: IDLE, BUSY, DONE. 8-bit down-counter `cnt`.
- IDLE:
  - If `valid_i` & `is_md` & !`flush_i`: `md_start`=1, `stall`=1, `cnt`←LAT-1, go to BUSY.
  - Otherwise stay in IDLE with `stall`=0.
- BUSY:
  - `stall`=1, `md_busy`=1.
  - If `cnt`==0, go to DONE; else `cnt`←`cnt`-1.
- DONE:
  - `md_done`=1, `stall`=0. The instruction retires this cycle; go to IDLE.
  - `valid_i`/`is_md` are ignored in DONE, so the same instruction is never re-issued.
- `flush_i` in BUSY or DONE: go to IDLE next cycle, `cnt`←0. No `md_done` in the cycle after the flush.
- `flush_i` in the BUSY cycle where `cnt`==0: flush wins; the FSM enters IDLE, not DONE.
- `illegal` = `valid_i` & (Operation==01111). An illegal op never starts the FSM.
- Non-M valid instructions in IDLE: `stall`=0, no state change.

## Timing
- Reset, effective at the next edge: state=IDLE, `cnt`=0, `md_busy`=0, `md_done`=0. `md_start`=0 and `stall`=0 unless IDLE issue conditions hold.
- Reset asserted during BUSY/DONE aborts like a flush; reset has priority over flush.
- M op latency: issue cycle + LAT BUSY cycles + 1 DONE cycle.
  - Total stall = LAT+1 cycles.
  - `md_done` is high exactly LAT+1 cycles after `md_start`.
- Back-to-back M ops:
  - The DONE cycle cannot issue.
  - The next M op issues the cycle after DONE, once the pipeline has advanced.
- `md_start`, `stall`, `illegal`, `Operation` are combinational from state + inputs. `md_busy`, `md_done` are decoded from registered state.

## Structure
- Package `alu_ctrl_pkg`:
  - 5-bit op code constants (base + M).
  - ALUOp constants.
  - FSM state enum.
  - Funct7 constants: 0000000, 0100000, 0000001.
- Sub-module `alu_op_decode`: purely combinational ALUOp/Funct7/Funct3 → Operation, parameter ENABLE_M.
- The top level holds the FSM, counter and handshake logic.

## Test plan
- Full decode sweep, every ALUOp × Funct7 {0000000, 0100000, 0000001, 1111111} × Funct3:
  - R SUB → 00110; I Funct3=000 with Funct7=0100000 → ADD 00010.
  - SRAI → 01001; SLLI with Funct7=0100000 → 01111 and `illegal`=1.
- MUL with MUL_LAT=4:
  - `md_start` at cycle 0, `stall` cycles 0–4, `md_busy` cycles 1–4, `md_done` at cycle 5 with `stall`=0.
- DIV with DIV_LAT=33:
  - `md_done` exactly 34 cycles after `md_start`.
  - Two consecutive DIVs → second `md_start` at cycle 35.
- Flush during BUSY (cycle 2 of MUL):
  - IDLE at cycle 3, no `md_done`, `stall`=0.
  - Reset mid-DIV gives the same result; reset+flush together → IDLE.
- ENABLE_M=0: MUL → Operation 01111, `illegal`=1, no `md_start`, no stall.
- `valid_i`=0 with M encoding → no `md_start`; Operation still 10000.
